// File: rtl/char_pkg.sv
// Constants, control codes and state type shared by the character display path.
package char_pkg;

    localparam int unsigned COLS   = 100;
    localparam int unsigned ROWS   = 75;
    localparam int unsigned ADDR_W = 13;

    localparam logic [7:0] BLANK_CHAR = 8'h20;
    localparam logic [7:0] CR         = 8'h0D;
    localparam logic [7:0] LF         = 8'h0A;
    localparam logic [7:0] BS         = 8'h08;
    localparam logic [7:0] FF         = 8'h0C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR_LINE,
        ST_CLR_SCREEN
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/char_text_writer_if.sv
// Character stream handshake plus character RAM write port.
interface char_text_writer_if;
    import char_pkg::*;

    logic              char_valid;
    logic [7:0]        char_code;
    logic              char_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    // master: code source and RAM observer; slave: the text writer
    modport master (output char_valid, char_code,
                    input  char_ready, wr_en, wr_addr, wr_data);
    modport slave  (input  char_valid, char_code,
                    output char_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/char_clear_seq.sv
// Ascending address generator for blank-fill runs (one line or whole screen).
module char_clear_seq
    import char_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_count,
    output logic              o_active,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_done
);

    logic              r_active;
    logic              r_done;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_left;

    // o_done pulses the cycle after the final address was presented
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_addr   <= '0;
            r_left   <= '0;
        end else if (i_start) begin
            r_active <= (i_count != '0);
            r_done   <= 1'b0;
            r_addr   <= i_base;
            r_left   <= i_count;
        end else if (r_active) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_left <= r_left - ADDR_W'(1);
            if (r_left == ADDR_W'(1)) begin
                r_active <= 1'b0;
                r_done   <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_active = r_active;
    assign o_addr   = r_addr;
    assign o_done   = r_done;

endmodule

// File: rtl/char_text_writer.sv
// Writes a stream of character codes into character RAM at a tracked cursor,
// handling CR/LF/BS/FF and line/screen wrap with hardware line clearing.
module char_text_writer
    import char_pkg::*;
(
    input  logic                pixel_clock,
    input  logic                nSYSPOR,
    char_text_writer_if.slave   bus,
    output logic [6:0]          cursor_col,
    output logic [6:0]          cursor_row,
    output logic                busy
);

    state_t            r_state, w_next_state;
    logic [6:0]        r_col, w_col, r_row, w_row;
    logic [ADDR_W-1:0] r_line_base, w_line_base;
    logic              r_wr_en, w_wr_en;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr;
    logic [7:0]        r_wr_data, w_wr_data;
    logic              r_busy, r_ready;

    logic              w_accept;
    logic              w_seq_start, w_seq_active, w_seq_done;
    logic [ADDR_W-1:0] w_seq_base, w_seq_count, w_seq_addr;
    logic [6:0]        w_adv_row;
    logic [ADDR_W-1:0] w_adv_base;

    assign w_accept   = bus.char_valid && r_ready;
    assign w_adv_row  = (r_row == 7'(ROWS - 1)) ? '0 : r_row + 7'd1;
    assign w_adv_base = (r_row == 7'(ROWS - 1)) ? '0 : r_line_base + ADDR_W'(COLS);

    char_clear_seq u_clear_seq (
        .i_clk    (pixel_clock),
        .i_rst_n  (nSYSPOR),
        .i_start  (w_seq_start),
        .i_base   (w_seq_base),
        .i_count  (w_seq_count),
        .o_active (w_seq_active),
        .o_addr   (w_seq_addr),
        .o_done   (w_seq_done)
    );

    // Next-state, cursor and write-port decode
    always_comb begin
        w_next_state = r_state;
        w_col        = r_col;
        w_row        = r_row;
        w_line_base  = r_line_base;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_wr_addr;
        w_wr_data    = r_wr_data;
        w_seq_start  = 1'b0;
        w_seq_base   = '0;
        w_seq_count  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (bus.char_code)
                        CR: w_col = '0;
                        // LF issues the first blank itself; the sequencer covers the rest
                        LF: begin
                            w_row        = w_adv_row;
                            w_line_base  = w_adv_base;
                            w_wr_en      = 1'b1;
                            w_wr_addr    = w_adv_base;
                            w_wr_data    = BLANK_CHAR;
                            w_seq_start  = 1'b1;
                            w_seq_base   = w_adv_base + ADDR_W'(1);
                            w_seq_count  = ADDR_W'(COLS - 1);
                            w_next_state = ST_CLR_LINE;
                        end
                        BS: begin
                            if (r_col != '0) begin
                                w_col     = r_col - 7'd1;
                                w_wr_en   = 1'b1;
                                w_wr_addr = r_line_base + ADDR_W'(r_col) - ADDR_W'(1);
                                w_wr_data = BLANK_CHAR;
                            end
                        end
                        FF: begin
                            w_col        = '0;
                            w_row        = '0;
                            w_line_base  = '0;
                            w_wr_en      = 1'b1;
                            w_wr_addr    = '0;
                            w_wr_data    = BLANK_CHAR;
                            w_seq_start  = 1'b1;
                            w_seq_base   = ADDR_W'(1);
                            w_seq_count  = ADDR_W'(COLS * ROWS - 1);
                            w_next_state = ST_CLR_SCREEN;
                        end
                        default: begin
                            if (is_printable(bus.char_code)) begin
                                w_wr_en   = 1'b1;
                                w_wr_addr = r_line_base + ADDR_W'(r_col);
                                w_wr_data = bus.char_code;
                                if (r_col != 7'(COLS - 1)) begin
                                    w_col = r_col + 7'd1;
                                end else begin
                                    w_col        = '0;
                                    w_row        = w_adv_row;
                                    w_line_base  = w_adv_base;
                                    w_seq_start  = 1'b1;
                                    w_seq_base   = w_adv_base;
                                    w_seq_count  = ADDR_W'(COLS);
                                    w_next_state = ST_CLR_LINE;
                                end
                            end
                        end
                    endcase
                end
            end
            ST_CLR_LINE, ST_CLR_SCREEN: begin
                if (w_seq_active) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = w_seq_addr;
                    w_wr_data = BLANK_CHAR;
                end
                if (w_seq_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clock or negedge nSYSPOR) begin
        if (!nSYSPOR) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_line_base <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_col       <= w_col;
            r_row       <= w_row;
            r_line_base <= w_line_base;
            r_wr_en     <= w_wr_en;
            r_wr_addr   <= w_wr_addr;
            r_wr_data   <= w_wr_data;
            r_busy      <= (w_next_state != ST_IDLE);
            r_ready     <= (w_next_state == ST_IDLE);
        end
    end

    assign bus.char_ready = r_ready;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign cursor_col     = r_col;
    assign cursor_row     = r_row;
    assign busy           = r_busy;

endmodule

// File: tb/tb_char_text_writer.sv
// Directed bench for char_text_writer with a write-stream scoreboard.
module tb_char_text_writer;
    import char_pkg::*;

    logic       pixel_clock = 1'b0;
    logic       nSYSPOR;
    logic [6:0] cursor_col;
    logic [6:0] cursor_row;
    logic       busy;

    char_text_writer_if bus_if ();

    int         errors = 0;
    int         checks = 0;
    int         exp_addr[$];
    logic [7:0] exp_data[$];
    int         mcol = 0;
    int         mrow = 0;

    always #5 pixel_clock = ~pixel_clock;

    char_text_writer dut (
        .pixel_clock (pixel_clock),
        .nSYSPOR     (nSYSPOR),
        .bus         (bus_if),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input logic [7:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic push_line(input int row);
        for (int c = 0; c < int'(COLS); c++) push(row * int'(COLS) + c, BLANK_CHAR);
    endtask

    // Reference behaviour: queue expected writes and advance the model cursor
    task automatic model(input logic [7:0] c);
        int base;
        base = mrow * int'(COLS);
        if (c >= 8'h20 && c <= 8'h7E) begin
            push(base + mcol, c);
            if (mcol < int'(COLS) - 1) mcol++;
            else begin
                mcol = 0;
                mrow = (mrow == int'(ROWS) - 1) ? 0 : mrow + 1;
                push_line(mrow);
            end
        end else if (c == CR) begin
            mcol = 0;
        end else if (c == LF) begin
            mrow = (mrow == int'(ROWS) - 1) ? 0 : mrow + 1;
            push_line(mrow);
        end else if (c == BS) begin
            if (mcol > 0) begin
                mcol--;
                push(base + mcol, BLANK_CHAR);
            end
        end else if (c == FF) begin
            mcol = 0;
            mrow = 0;
            for (int i = 0; i < int'(COLS * ROWS); i++) push(i, BLANK_CHAR);
        end
    endtask

    // Advance one clock and score any write seen just after the edge
    task automatic tick();
        int a;
        logic [7:0] d;
        @(posedge pixel_clock);
        #1;
        if (bus_if.wr_en === 1'b1) begin
            if (exp_addr.size() == 0) begin
                chk("spurious_wr", 32'(bus_if.wr_en), 32'd0);
            end else begin
                a = exp_addr.pop_front();
                d = exp_data.pop_front();
                chk("wr_addr", 32'(bus_if.wr_addr), 32'(a));
                chk("wr_data", 32'(bus_if.wr_data), 32'(d));
            end
        end
    endtask

    task automatic drive(input logic [7:0] c);
        int n;
        n = 0;
        model(c);
        bus_if.char_valid = 1'b1;
        bus_if.char_code  = c;
        while (bus_if.char_ready !== 1'b1 && n < 20000) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(bus_if.char_ready), 32'd1);
        tick();
        bus_if.char_valid = 1'b0;
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (bus_if.char_ready !== 1'b1 && n < 20000) begin
            tick();
            n++;
        end
        bus_if.char_valid = 1'b0;
        chk("idle_wait", 32'(bus_if.char_ready), 32'd1);
        chk("pending", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic send(input logic [7:0] c);
        drive(c);
        settle();
    endtask

    task automatic chk_cursor(input string tag, input int col, input int row);
        chk({tag, "_col"}, 32'(cursor_col), 32'(col));
        chk({tag, "_row"}, 32'(cursor_row), 32'(row));
    endtask

    initial begin
        int n;
        nSYSPOR           = 1'b0;
        bus_if.char_valid = 1'b0;
        bus_if.char_code  = 8'h00;
        repeat (3) @(posedge pixel_clock);
        #1 nSYSPOR = 1'b1;
        tick();
        chk("rst_wr_en", 32'(bus_if.wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus_if.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus_if.wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus_if.char_ready), 32'd1);
        chk_cursor("rst", 0, 0);

        // Single printable at home
        drive(8'h41);
        chk("A_ready", 32'(bus_if.char_ready), 32'd1);
        chk_cursor("A", 1, 0);
        settle();

        // FF with valid held high throughout the clear
        drive(FF);
        chk("ff_busy", 32'(busy), 32'd1);
        chk("ff_ready", 32'(bus_if.char_ready), 32'd0);
        chk_cursor("ff", 0, 0);
        bus_if.char_valid = 1'b1;
        bus_if.char_code  = 8'h51;
        settle();
        tick();
        tick();
        chk_cursor("ff_done", 0, 0);
        chk("ff_idle_busy", 32'(busy), 32'd0);

        // Walk to (99,3) then wrap with a printable
        for (int i = 0; i < 3; i++) send(LF);
        for (int i = 0; i < 99; i++) send(8'h61 + 8'(i % 26));
        chk_cursor("pre_Z", 99, 3);
        drive(8'h5A);
        chk("Z_busy", 32'(busy), 32'd1);
        chk("Z_ready", 32'(bus_if.char_ready), 32'd0);
        settle();
        chk_cursor("Z", 0, 4);

        // LF on the last row wraps to row 0
        for (int i = 0; i < 70; i++) send(LF);
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
        chk_cursor("pre_lf", 5, 74);
        send(LF);
        chk_cursor("lf_wrap", 5, 0);

        // Printable at the very last cell wraps to row 0 and clears it
        for (int i = 0; i < 74; i++) send(LF);
        for (int i = 0; i < 94; i++) send(8'h41 + 8'(i % 26));
        chk_cursor("pre_last", 99, 74);
        send(8'h7E);
        chk_cursor("last_wrap", 0, 0);

        // BS, including at column 0
        for (int i = 0; i < 2; i++) send(LF);
        for (int i = 0; i < 3; i++) send(8'h62);
        chk_cursor("pre_bs", 3, 2);
        send(BS);
        chk_cursor("bs", 2, 2);
        send(BS);
        send(BS);
        send(BS);
        chk_cursor("bs_col0", 0, 2);

        // CR and an ignored control code
        for (int i = 0; i < 5; i++) send(LF);
        for (int i = 0; i < 40; i++) send(8'h63);
        chk_cursor("pre_cr", 40, 7);
        send(CR);
        chk_cursor("cr", 0, 7);
        send(8'h01);
        chk_cursor("ignored", 0, 7);
        chk_cursor("model", mcol, mrow);

        // Reset while clearing the screen
        drive(FF);
        n = 0;
        while (!(bus_if.wr_en === 1'b1 && bus_if.wr_addr == 13'd3000) && n < 10000) begin
            tick();
            n++;
        end
        chk("reach_3000", 32'(bus_if.wr_addr), 32'd3000);
        nSYSPOR = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(bus_if.wr_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        mcol = 0;
        mrow = 0;
        #2 nSYSPOR = 1'b1;
        repeat (4) tick();
        chk_cursor("post_rst", 0, 0);
        chk("post_rst_ready", 32'(bus_if.char_ready), 32'd1);
        chk("post_rst_wr_en", 32'(bus_if.wr_en), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/char_text_writer.md
Name: char_text_writer

Overview:
- Upstream feeder for the character display path. Takes a stream of 8-bit character codes over a valid/ready handshake and writes them into the character RAM write port at a tracked cursor position.
- The RAM read side is scanned by the character generator using char_column and char_line.
- Handles printable characters, CR, LF, BS and FF (clear screen).
- Handles end-of-line wrap and end-of-screen wrap to the top line; the incoming line is cleared in hardware.
- Runs in the pixel_clock domain.

Parameters:
- COLS, 100, characters per line (800 px / 8).
- ROWS, 75, lines per screen (600 px / 8).
- ADDR_W, 13, RAM address width; must satisfy 2^ADDR_W >= COLS*ROWS.
- BLANK_CHAR, 8'h20, code written when clearing cells.

Ports:
- pixel_clock  in  1  block clock.
- nSYSPOR  in  1  reset; one clock; reset is asynchronous and active-low.
- char_valid  in  1  char_code is valid.
- char_code  in  8  character or control code.
- char_ready  out  1  block can accept a code this cycle.
- wr_en  out  1  RAM write strobe, one write per cycle.
- wr_addr  out  ADDR_W  RAM address, row*COLS+col.
- wr_data  out  8  RAM write data.
- cursor_col  out  7  current cursor column, 0..COLS-1.
- cursor_row  out  7  current cursor row, 0..ROWS-1.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset values:
  - Cursor is (0,0).
  - wr_en=0, wr_addr=0, wr_data=0, busy=0.
  - State is IDLE and char_ready=1.
- States:
  - IDLE: char_ready=1.
  - CLR_LINE: clears one line.
  - CLR_SCREEN: clears the whole screen.
  - char_ready=0 in both clear states.
- Accept: a transfer happens when char_valid && char_ready (cycle N). All outputs are registered; effects appear at N+1.
- Printable (0x20..0x7E):
  - At N+1: wr_en=1, wr_addr=row*COLS+col, wr_data=code.
  - If col<COLS-1: col+1 at N+1.
  - Else: col=0, row=(row==ROWS-1)?0:row+1, then enter CLR_LINE for the new row.
- CR 0x0D: col=0, no write.
- LF 0x0A:
  - row advances with the same wrap rule as above.
  - col is unchanged.
  - Enter CLR_LINE for the new row.
- BS 0x08:
  - If col>0: col-1 and write BLANK_CHAR at the new position.
  - If col==0: no effect.
- FF 0x0C: cursor=(0,0), enter CLR_SCREEN.
- Other codes: accepted and ignored (no write, no cursor change).
- CLR_LINE:
  - Starting at N+1, COLS consecutive writes of BLANK_CHAR at row*COLS+0 .. row*COLS+COLS-1.
  - For a printable-triggered wrap, the printable write occupies cycle N+1 and the clear starts at N+2.
  - busy=1 for the duration.
  - char_ready returns to 1 the cycle after the last clear write.
- CLR_SCREEN:
  - COLS*ROWS writes of BLANK_CHAR at addresses 0..COLS*ROWS-1, ascending, one per cycle.
  - Then return to IDLE.
- wr_en is 0 in every cycle without a write. char_valid is ignored while char_ready=0; the source must hold its data.
- Address arithmetic:
  - row*COLS is computed from registered row.
  - No multiplier on the critical path is required; keep a registered line_base updated by ±COLS.
- Reset mid-clear: the sequence aborts immediately and all state returns to reset values. RAM contents are undefined until the next FF.
- Simultaneous events: only one code is accepted per cycle, so there are none. A printable at the last column of the last row wraps to row 0 and clears row 0.

Decomposition:
- Shared package (char_pkg):
  - Constants COLS, ROWS, ADDR_W, BLANK_CHAR.
  - Control code constants CR, LF, BS, FF.
  - State enum.
  - These constants are shared with the timing generator and character display.
- One natural sub-module: char_clear_seq.
  - Interface: start, base address, count, done.
  - Generates the ascending blank-write address stream for both CLR_LINE and CLR_SCREEN.
- The FSM and cursor logic stay in the top of this block.

Test Plan:
- Reset, then send 'A'(0x41) at (0,0): exactly one write addr=0 data=0x41; cursor becomes (1,0); char_ready stays 1.
- Cursor at (99,3), send 'Z':
  - Write addr=399 data=0x5A.
  - Then 100 writes of 0x20 at addr 400..499 with busy=1 and char_ready=0.
  - Cursor ends at (0,4).
- Cursor at (5,74), send LF: clears addr 0..99; cursor ends at (5,0).
- Cursor at (3,2):
  - Send BS: write addr=202 data=0x20, cursor (2,2).
  - At col 0, BS gives no write and no cursor change.
  - Send CR from (40,7): cursor (0,7), no write.
- Send FF: 7500 writes of 0x20 at addr 0..7499, cursor (0,0); char_valid held high during the clear is not accepted.
- Assert nSYSPOR low mid-CLR_SCREEN (at addr 3000): wr_en=0 immediately; after release cursor=(0,0) and char_ready=1.
